seg7_scan_decoder: RTL and testbench

- Receive side of the multiplexed 7-segment display interface.
- Samples the active-low segment bus and the active-low digit-select lines, and debounces each scanned pattern.
- Converts each segment pattern back to a 4-bit hex value, with blank, decimal-point and invalid flags.
- Assembles one value per digit into a frame and presents the frame on a valid/ready output for test or loop-back checking.

---
 rtl/seg7_scan_decoder.sv | 196 +++++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// Receive side of a multiplexed 7-segment display: debounces scanned digits, decodes them, and emits frames on valid/ready.
// Optional macro SEG7_DP_CAPTURE_EN enables decimal-point capture; when undefined, seg_n[0] is ignored.
module seg7_scan_decoder #(
  parameter int unsigned DIGITS        = 8,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            seg_n,
  input  logic [DIGITS-1:0]     an_n,
  output logic [4*DIGITS-1:0]   out_hex,
  output logic [DIGITS-1:0]     out_blank,
  output logic [DIGITS-1:0]     out_err,
  output logic [DIGITS-1:0]     out_dp,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overflow
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned HW = 4 * DIGITS;
`ifdef SEG7_DP_CAPTURE_EN
  localparam int unsigned KW = DIGITS + 8;
`else
  localparam int unsigned KW = DIGITS + 7;
`endif
  localparam logic [CW-1:0] RUN_MAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] RUN_LAST = CW'(STABLE_CYCLES - 1);

  // Reverse lookup of lit segments (a..g, active-high) to {blank, err, hex}
  function automatic logic [5:0] decode(input logic [6:0] segs);
    case (segs)
      7'b1111110: decode = {2'b00, 4'h0};
      7'b0110000: decode = {2'b00, 4'h1};
      7'b1101101: decode = {2'b00, 4'h2};
      7'b1111001: decode = {2'b00, 4'h3};
      7'b0110011: decode = {2'b00, 4'h4};
      7'b1011011: decode = {2'b00, 4'h5};
      7'b1011111: decode = {2'b00, 4'h6};
      7'b1110000: decode = {2'b00, 4'h7};
      7'b1111111: decode = {2'b00, 4'h8};
      7'b1111011: decode = {2'b00, 4'h9};
      7'b1110111: decode = {2'b00, 4'hA};
      7'b0011111: decode = {2'b00, 4'hB};
      7'b1001110: decode = {2'b00, 4'hC};
      7'b0111101: decode = {2'b00, 4'hD};
      7'b1001111: decode = {2'b00, 4'hE};
      7'b1000111: decode = {2'b00, 4'hF};
      7'b0000000: decode = {2'b10, 4'h0};
      default:    decode = {2'b01, 4'h0};
    endcase
  endfunction

  logic [KW-1:0]     r_prev;
  logic              r_prev_vld;
  logic [CW-1:0]     r_run;
  logic [DIGITS-1:0] r_mask;
  logic [HW-1:0]     r_slot_hex;
  logic [DIGITS-1:0] r_slot_blank;
  logic [DIGITS-1:0] r_slot_err;
  logic [HW-1:0]     r_out_hex;
  logic [DIGITS-1:0] r_out_blank;
  logic [DIGITS-1:0] r_out_err;
  logic              r_out_valid;
  logic              r_overflow;

  logic [KW-1:0]     w_key;
  logic              w_same;
  logic [CW-1:0]     w_run_nxt;
  logic              w_run_hit;
  logic [DIGITS-1:0] w_sel;
  logic              w_onehot;
  logic              w_commit;
  logic [5:0]        w_dec;
  logic [DIGITS-1:0] w_mask_nxt;
  logic              w_done;
  logic              w_load;
  logic [HW-1:0]     w_nxt_hex;
  logic [DIGITS-1:0] w_nxt_blank;
  logic [DIGITS-1:0] w_nxt_err;

`ifdef SEG7_DP_CAPTURE_EN
  logic [DIGITS-1:0] r_slot_dp;
  logic [DIGITS-1:0] r_out_dp;
  logic [DIGITS-1:0] w_nxt_dp;
  assign w_key = {an_n, seg_n};
`else
  logic w_unused_dp;
  assign w_key       = {an_n, seg_n[7:1]};
  assign w_unused_dp = seg_n[0];
`endif

  // Run-length filter: a commit fires once, on the edge the run reaches STABLE_CYCLES
  assign w_same    = r_prev_vld && (w_key == r_prev);
  assign w_run_nxt = !w_same ? CW'(1) : ((r_run == RUN_MAX) ? r_run : r_run + CW'(1));
  assign w_run_hit = w_same ? (r_run == RUN_LAST) : (STABLE_CYCLES == 1);

  assign w_sel    = ~an_n;
  assign w_onehot = (w_sel != '0) && ((w_sel & (w_sel - DIGITS'(1))) == '0);
  assign w_commit = w_run_hit && w_onehot;
  assign w_dec    = decode(~seg_n[7:1]);

  assign w_mask_nxt = r_mask | w_sel;
  assign w_done     = w_commit && (w_mask_nxt == {DIGITS{1'b1}});
  assign w_load     = w_done && (!r_out_valid || out_ready);

  // Slot contents including the digit being committed this edge
  always_comb begin
    w_nxt_hex   = r_slot_hex;
    w_nxt_blank = r_slot_blank;
    w_nxt_err   = r_slot_err;
`ifdef SEG7_DP_CAPTURE_EN
    w_nxt_dp    = r_slot_dp;
`endif
    for (int i = 0; i < DIGITS; i++) begin
      if (w_sel[i]) begin
        w_nxt_hex[4*i +: 4] = w_dec[3:0];
        w_nxt_blank[i]      = w_dec[5];
        w_nxt_err[i]        = w_dec[4];
`ifdef SEG7_DP_CAPTURE_EN
        w_nxt_dp[i]         = ~seg_n[0];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev     <= '0;
      r_prev_vld <= 1'b0;
      r_run      <= '0;
    end else begin
      r_prev     <= w_key;
      r_prev_vld <= 1'b1;
      r_run      <= w_run_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask       <= '0;
      r_slot_hex   <= '0;
      r_slot_blank <= '0;
      r_slot_err   <= '0;
`ifdef SEG7_DP_CAPTURE_EN
      r_slot_dp    <= '0;
`endif
    end else if (w_commit) begin
      r_mask       <= w_done ? '0 : w_mask_nxt;
      r_slot_hex   <= w_nxt_hex;
      r_slot_blank <= w_nxt_blank;
      r_slot_err   <= w_nxt_err;
`ifdef SEG7_DP_CAPTURE_EN
      r_slot_dp    <= w_nxt_dp;
`endif
    end
  end

  // Output frame register with valid/ready handshake and sticky drop flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_hex   <= '0;
      r_out_blank <= '0;
      r_out_err   <= '0;
`ifdef SEG7_DP_CAPTURE_EN
      r_out_dp    <= '0;
`endif
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (w_load) begin
      r_out_hex   <= w_nxt_hex;
      r_out_blank <= w_nxt_blank;
      r_out_err   <= w_nxt_err;
`ifdef SEG7_DP_CAPTURE_EN
      r_out_dp    <= w_nxt_dp;
`endif
      r_out_valid <= 1'b1;
    end else if (w_done) begin
      r_overflow  <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_hex   = r_out_hex;
  assign out_blank = r_out_blank;
  assign out_err   = r_out_err;
  assign out_valid = r_out_valid;
  assign overflow  = r_overflow;
`ifdef SEG7_DP_CAPTURE_EN
  assign out_dp    = r_out_dp;
`else
  assign out_dp    = '0;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder with DIGITS=2, STABLE_CYCLES=4.
module tb_seg7_scan_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] seg_n;
  logic [1:0] an_n;
  logic [7:0] out_hex;
  logic [1:0] out_blank;
  logic [1:0] out_err;
  logic [1:0] out_dp;
  logic       out_valid;
  logic       out_ready;
  logic       overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  seg7_scan_decoder #(.DIGITS(2), .STABLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .seg_n(seg_n), .an_n(an_n),
    .out_hex(out_hex), .out_blank(out_blank), .out_err(out_err), .out_dp(out_dp),
    .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] s0;
    logic [7:0] s1;
    logic [7:0] hex;
    logic [1:0] blank;
    logic [1:0] err;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [1:0] an, input logic [7:0] seg, input logic rdy, input int n);
    for (int k = 0; k < n; k++) begin
      an_n      = an;
      seg_n     = seg;
      out_ready = rdy;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2'b11, 8'hFF, 1'b0, 1);
    rst = 1'b0;
  endtask

  logic [1:0] dp_exp;
  logic       dp_ign_valid;

  initial begin
    vecs[0] = '{s0: 8'h03, s1: 8'h9F, hex: 8'h10, blank: 2'b00, err: 2'b00};
    vecs[1] = '{s0: 8'hFF, s1: 8'h55, hex: 8'h00, blank: 2'b01, err: 2'b10};
    vecs[2] = '{s0: 8'h25, s1: 8'h01, hex: 8'h82, blank: 2'b00, err: 2'b00};
    vecs[3] = '{s0: 8'h11, s1: 8'h71, hex: 8'hFA, blank: 2'b00, err: 2'b00};
    vecs[4] = '{s0: 8'hC1, s1: 8'h1F, hex: 8'h7B, blank: 2'b00, err: 2'b00};
`ifdef SEG7_DP_CAPTURE_EN
    dp_exp       = 2'b01;
    dp_ign_valid = 1'b0;
`else
    dp_exp       = 2'b00;
    dp_ign_valid = 1'b1;
`endif

    rst = 1'b1; an_n = 2'b11; seg_n = 8'hFF; out_ready = 1'b0;
    step(2'b11, 8'hFF, 1'b0, 2);
    chk("reset_state", {out_hex, out_blank, out_err, out_dp, out_valid, overflow}, '0);
    rst = 1'b0;

    // Table-driven frames
    for (int v = 0; v < 5; v++) begin
      do_reset();
      step(2'b10, vecs[v].s0, 1'b0, 4);
      step(2'b01, vecs[v].s1, 1'b0, 3);
      chk($sformatf("v%0d_valid_early", v), 32'(out_valid), 32'd0);
      step(2'b01, vecs[v].s1, 1'b0, 1);
      chk($sformatf("v%0d_valid", v), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_hex", v), 32'(out_hex), 32'(vecs[v].hex));
      chk($sformatf("v%0d_blank", v), 32'(out_blank), 32'(vecs[v].blank));
      chk($sformatf("v%0d_err", v), 32'(out_err), 32'(vecs[v].err));
      step(2'b11, 8'hFF, 1'b1, 1);
      chk($sformatf("v%0d_drain", v), 32'(out_valid), 32'd0);
    end

    // Digit 0 too short to commit
    do_reset();
    step(2'b10, 8'h11, 1'b0, 3);
    step(2'b01, 8'h9F, 1'b0, 4);
    step(2'b11, 8'hFF, 1'b0, 2);
    chk("short_run_valid", 32'(out_valid), 32'd0);

    // Overflow, hold, and simultaneous accept+load
    do_reset();
    step(2'b10, 8'h03, 1'b0, 4);
    step(2'b01, 8'h9F, 1'b0, 4);
    step(2'b10, 8'h25, 1'b0, 4);
    step(2'b01, 8'h01, 1'b0, 4);
    chk("ovf_hold_hex", 32'(out_hex), 32'h10);
    chk("ovf_hold_valid", 32'(out_valid), 32'd1);
    chk("ovf_flag", 32'(overflow), 32'd1);
    step(2'b10, 8'h11, 1'b0, 4);
    step(2'b01, 8'h71, 1'b0, 3);
    step(2'b01, 8'h71, 1'b1, 1);
    chk("same_edge_hex", 32'(out_hex), 32'hFA);
    chk("same_edge_valid", 32'(out_valid), 32'd1);
    step(2'b11, 8'hFF, 1'b1, 1);
    chk("same_edge_drain", 32'(out_valid), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Reset mid-frame discards committed digit 0
    do_reset();
    step(2'b10, 8'h03, 1'b0, 4);
    do_reset();
    step(2'b01, 8'h9F, 1'b0, 4);
    step(2'b11, 8'hFF, 1'b0, 1);
    chk("midrst_outputs", {out_hex, out_blank, out_err, out_dp, out_valid, overflow}, '0);

    // Multiple selects low commit nothing
    do_reset();
    step(2'b00, 8'h03, 1'b0, 4);
    step(2'b01, 8'h9F, 1'b0, 4);
    chk("multisel_valid", 32'(out_valid), 32'd0);
    step(2'b10, 8'h03, 1'b0, 4);
    chk("multisel_then_ok", 32'({out_valid, out_hex}), 32'h110);

    // Decimal point capture
    do_reset();
    step(2'b10, 8'h02, 1'b0, 4);
    step(2'b01, 8'h9F, 1'b0, 4);
    chk("dp_hex", 32'(out_hex), 32'h10);
    chk("dp_bits", 32'(out_dp), 32'(dp_exp));

    // A dp-only change restarts the run only when dp is captured
    do_reset();
    step(2'b10, 8'h03, 1'b0, 2);
    step(2'b10, 8'h02, 1'b0, 2);
    step(2'b01, 8'h9F, 1'b0, 4);
    chk("dp_only_change", 32'(out_valid), 32'(dp_ign_valid));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
